// File: rtl/alu_cmd_initiator.sv
// Requester for the 4-bit opcode ALU: registers a command onto the ALU buses,
// waits LAT cycles and returns the normalised result over valid/ready.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/ready/opcode/a/b        command channel
//   alu_opcode/a/b (out), alu_x/y     registered ALU operands, ALU results
//   rsp_valid/ready/result/opcode/err response channel
//   busy                              high whenever not IDLE
//   op_count                          saturating count of completed responses
module alu_cmd_initiator #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_x,
    input  logic [WIDTH-1:0]   alu_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic [3:0]         rsp_opcode,
    output logic               rsp_err,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int RW = 2 * WIDTH;
    // Shift-amount limit; 2*WIDTH always fits in WIDTH+1 bits.
    localparam logic [WIDTH:0] SH_LIM = (WIDTH + 1)'(RW);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    wait_cnt;
    logic          accept;
    logic          sample;
    logic          complete;
    logic [RW-1:0] norm;
    logic          err;
    logic          cls_bit, cls_x, cls_cy, cls_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        sample    = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (wait_cnt == 4'd0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Opcode classes are disjoint and together cover all 16 codes.
    always_comb begin
        cls_bit = (alu_opcode <= 4'd2) ||
                  (alu_opcode >= 4'd6 && alu_opcode <= 4'd9);
        cls_x   = (alu_opcode >= 4'd3 && alu_opcode <= 4'd5) ||
                  (alu_opcode == 4'd11) || (alu_opcode == 4'd15);
        cls_cy  = (alu_opcode == 4'd10);
        cls_raw = (alu_opcode >= 4'd12 && alu_opcode <= 4'd14);
    end

    always_comb begin
        norm = '0;
        unique case (1'b1)
            cls_bit: norm = RW'(alu_x[0]);
            cls_x:   norm = RW'(alu_x);
            cls_cy:  norm = RW'({alu_y[0], alu_x});
            cls_raw: norm = {alu_y, alu_x};
            default: norm = '0;
        endcase
    end

    // Error comes from the held operands, not from the ALU outputs.
    always_comb begin
        err = 1'b0;
        if (alu_opcode == 4'd11 && alu_a < alu_b)
            err = 1'b1;
        if ((alu_opcode == 4'd13 || alu_opcode == 4'd14) &&
            {1'b0, alu_b} >= SH_LIM)
            err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            wait_cnt   <= '0;
            rsp_result <= '0;
            rsp_opcode <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= cmd_opcode;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                wait_cnt   <= 4'(LAT - 1);
            end else if (state == DRIVE && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (sample) begin
                rsp_result <= norm;
                rsp_opcode <= alu_opcode;
                rsp_err    <= err;
            end
            if (complete && op_count != '1)
                op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench for alu_cmd_initiator: LAT=1 and LAT=3 instances
// driven against a stub ALU, with hand-computed expected responses.
module tb_alu_cmd_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stub ALU: add, subtract, multiply, otherwise XOR into X.
    function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            4'b1010: return 8'(a) + 8'(b);
            4'b1011: return {4'h0, a - b};
            4'b1100: return 8'(a) * 8'(b);
            default: return {4'h0, a ^ b};
        endcase
    endfunction

    // LAT=1 instance
    logic       cv1 = 0, rr1 = 0, ovr1 = 0;
    logic [3:0] cop1 = 0, ca1 = 0, cb1 = 0;
    logic       crdy1, rv1, rerr1, busy1;
    logic [3:0] aop1, aa1, ab1, ax1, ay1, rop1;
    logic [7:0] res1, cnt1;

    assign {ay1, ax1} = ovr1 ? 8'hFF : alu_fn(aop1, aa1, ab1);

    alu_cmd_initiator #(.WIDTH(4), .LAT(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv1), .cmd_ready(crdy1),
        .cmd_opcode(cop1), .cmd_a(ca1), .cmd_b(cb1),
        .alu_opcode(aop1), .alu_a(aa1), .alu_b(ab1),
        .alu_x(ax1), .alu_y(ay1),
        .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_result(res1), .rsp_opcode(rop1), .rsp_err(rerr1),
        .busy(busy1), .op_count(cnt1)
    );

    // LAT=3 instance
    logic       cv3 = 0, rr3 = 0;
    logic [3:0] cop3 = 0, ca3 = 0, cb3 = 0;
    logic       crdy3, rv3, rerr3, busy3;
    logic [3:0] aop3, aa3, ab3, ax3, ay3, rop3;
    logic [7:0] res3, cnt3;

    assign {ay3, ax3} = alu_fn(aop3, aa3, ab3);

    alu_cmd_initiator #(.WIDTH(4), .LAT(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv3), .cmd_ready(crdy3),
        .cmd_opcode(cop3), .cmd_a(ca3), .cmd_b(cb3),
        .alu_opcode(aop3), .alu_a(aa3), .alu_b(ab3),
        .alu_x(ax3), .alu_y(ay3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_result(res3), .rsp_opcode(rop3), .rsp_err(rerr3),
        .busy(busy3), .op_count(cnt3)
    );

    // One command through the LAT=1 instance, response checked then drained.
    task automatic run1(input string tag, input logic [3:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] er, input logic ee);
        int n;
        cv1 = 1; cop1 = op; ca1 = a; cb1 = b;
        @(negedge clk);
        cv1 = 0;
        n = 0;
        while (!rv1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_res"}, res1, er);
        chk({tag, "_err"}, rerr1, ee);
        chk({tag, "_op"}, rop1, op);
        rr1 = 1;
        @(negedge clk);
        rr1 = 0;
    endtask

    initial begin
        int n, hs, pulses;

        // Reset state
        #1;
        chk("rst_ready", crdy1, 1);
        chk("rst_valid", rv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_cnt", cnt1, 0);
        chk("rst_aop", aop1, 0);
        chk("rst_res", res1, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Carry-class op: buses registered on accept, result {Y[0],X}
        cv1 = 1; cop1 = 4'b1010; ca1 = 4'd9; cb1 = 4'd8;
        @(negedge clk);
        cv1 = 0;
        chk("t1_aop", aop1, 4'b1010);
        chk("t1_aa", aa1, 4'd9);
        chk("t1_ab", ab1, 4'd8);
        chk("t1_drive_rdy", crdy1, 0);
        chk("t1_drive_vld", rv1, 0);
        @(negedge clk);
        chk("t1_vld", rv1, 1);
        chk("t1_res", res1, 8'h11);
        chk("t1_err", rerr1, 0);
        rr1 = 1;
        @(negedge clk);
        rr1 = 0;
        chk("t1_cnt", cnt1, 1);
        chk("t1_idle_rdy", crdy1, 1);

        // Subtract with borrow, then bit-class with ALU forced to FF
        run1("sub", 4'b1011, 4'd3, 4'd5, 8'h0E, 1'b1);
        ovr1 = 1;
        run1("bit", 4'b0110, 4'd7, 4'd2, 8'h01, 1'b0);
        ovr1 = 0;

        // Shift-limit boundary: B=7 no error, B=8 error
        run1("sh7", 4'b1101, 4'd1, 4'd7, 8'h06, 1'b0);
        run1("sh8", 4'b1101, 4'd1, 4'd8, 8'h09, 1'b1);

        // Backpressure while a new command waits
        cv1 = 1; cop1 = 4'b0011; ca1 = 4'd5; cb1 = 4'd6;
        @(negedge clk);
        cop1 = 4'b0100; ca1 = 4'd2; cb1 = 4'd3;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", rv1, 1);
            chk("bp_res", res1, 8'h03);
            chk("bp_rdy", crdy1, 0);
            @(negedge clk);
        end
        rr1 = 1;
        @(negedge clk);
        rr1 = 0;
        chk("bp_idle_rdy", crdy1, 1);
        chk("bp_bus_hold", aop1, 4'b0011);
        @(negedge clk);
        cv1 = 0;
        chk("bp_next_aop", aop1, 4'b0100);
        chk("bp_next_busy", busy1, 1);
        @(negedge clk);
        chk("bp_next_res", res1, 8'h01);
        rr1 = 1;
        @(negedge clk);
        rr1 = 0;

        // rsp_ready high in advance: one-cycle response, overshift error
        rr1 = 1;
        cv1 = 1; cop1 = 4'b1110; ca1 = 4'd1; cb1 = 4'd9;
        @(negedge clk);
        cv1 = 0;
        @(negedge clk);
        chk("pre_vld", rv1, 1);
        chk("pre_res", res1, 8'h08);
        chk("pre_err", rerr1, 1);
        @(negedge clk);
        chk("pre_vld_gone", rv1, 0);
        rr1 = 0;

        // LAT=3: response three edges after accept, four not-ready cycles
        cv3 = 1; cop3 = 4'b1100; ca3 = 4'd15; cb3 = 4'd15;
        @(negedge clk);
        cv3 = 0;
        pulses = crdy3 ? 0 : 1;
        n = 0;
        while (!rv3 && n < 20) begin
            @(negedge clk);
            n++;
            if (!crdy3) pulses++;
        end
        chk("l3_lat", n, 3);
        chk("l3_notrdy", pulses, 4);
        chk("l3_res", res3, 8'hE1);
        rr3 = 1;
        @(negedge clk);
        rr3 = 0;
        chk("l3_cnt", cnt3, 1);

        // Saturation: 260 back-to-back commands
        cv1 = 1; cop1 = 4'b0000; ca1 = 4'd1; cb1 = 4'd1;
        rr1 = 1;
        hs = 0;
        n = 0;
        while (hs < 260 && n < 2000) begin
            @(negedge clk);
            n++;
            if (rv1) hs++;
        end
        cv1 = 0;
        chk("sat_hs", hs, 260);
        @(negedge clk);
        rr1 = 0;
        chk("sat_cnt", cnt1, 8'd255);
        chk("sat_busy", busy1, 0);

        // Reset in the middle of a LAT=3 DRIVE
        cv3 = 1; cop3 = 4'b1010; ca3 = 4'd1; cb3 = 4'd2;
        @(negedge clk);
        cv3 = 0;
        @(negedge clk);
        chk("mr_in_drive", busy3, 1);
        rst_n = 0;
        #1;
        chk("mr_busy", busy3, 0);
        chk("mr_rdy", crdy3, 1);
        chk("mr_aop", aop3, 0);
        chk("mr_cnt3", cnt3, 0);
        chk("mr_cnt1", cnt1, 0);
        @(negedge clk);
        rst_n = 1;
        rr3 = 1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rv3) pulses++;
        end
        rr3 = 0;
        chk("mr_no_rsp", pulses, 0);
        chk("mr_cnt_after", cnt3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_initiator.md
Name: alu_cmd_initiator

Overview:
- Requester side of the 4-bit ALU opcode interface. It accepts one command {opcode, A, B} over a valid/ready handshake and drives the ALU operand and opcode buses.
- It waits a programmable settle latency, samples the ALU outputs {Y, X} and normalises the result per opcode class.
- It returns the result over a valid/ready response channel and keeps an error flag and an op counter.
- It sits between the control logic and the combinational ALU, so the ALU becomes a registered, flow-controlled resource.

Parameters:
- WIDTH, 4, operand width; ALU result bus is 2*WIDTH ({Y, X}).
- LAT, 1, cycles the ALU buses are held before sampling; legal range 1..15.
- CNT_W, 8, op_count width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  initiator can accept a command.
- cmd_opcode  input  4  ALU opcode.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- alu_opcode  output  4  registered opcode to ALU.
- alu_a  output  WIDTH  registered A to ALU.
- alu_b  output  WIDTH  registered B to ALU.
- alu_x  input  WIDTH  ALU low result.
- alu_y  input  WIDTH  ALU high result.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  2*WIDTH  normalised {Y, X}.
- rsp_opcode  output  4  opcode of this response.
- rsp_err  output  1  borrow or overshift flag.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  completed responses, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cmd_ready=1; rsp_valid=0; busy=0. alu_opcode, alu_a, alu_b, rsp_result, rsp_opcode, rsp_err, op_count and the wait counter are all 0.
- FSM has three states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register the opcode/A/B onto the alu_* buses, load wait counter=LAT-1 and go to DRIVE.
  - DRIVE: cmd_ready=0 and the alu_* buses are stable. Each cycle with counter!=0, decrement. When counter==0, sample alu_y/alu_x into rsp_result (normalised), set rsp_opcode and rsp_err, and go to RESP.
  - RESP: rsp_valid=1 and all rsp_* outputs are held stable until rsp_valid&rsp_ready. On that handshake, increment op_count (saturating at 2^CNT_W-1) and go to IDLE.
- Latency: a command accepted at edge k gives rsp_valid=1 after edge k+LAT. The earliest next acceptance is one edge after the response handshake. Only one command is outstanding at a time.
- cmd_ready is combinational from state only; it does not depend on cmd_valid.
- The alu_* buses keep their last values outside DRIVE and change only at acceptance.
- Normalisation (R = {alu_y, alu_x}):
  - Opcodes 0000-0010 and 0110-1001: result = {0…, alu_x[0]}.
  - Opcodes 0011-0101, 1011, 1111: result = {0…, alu_x}.
  - Opcode 1010: result = {0…, alu_y[0], alu_x}.
  - Opcodes 1100-1110: result = R unmodified.
- rsp_err:
  - Set to 1 for opcode 1011 when A<B (unsigned borrow).
  - Set to 1 for opcode 1101/1110 when B >= 2*WIDTH.
  - 0 for all other cases.
  - Computed from the registered alu_a/alu_b, not from the ALU outputs.
- Boundary conditions:
  - cmd_valid while busy: ignored. The caller must hold it, and it is accepted on the cycle the state returns to IDLE.
  - rsp_ready held high before rsp_valid: the handshake completes on the first RESP cycle, so the response is visible for exactly 1 cycle.
  - Deasserting rsp_ready mid-RESP: the response is held indefinitely with no change to any rsp_* output.
  - op_count at max: stays at max.
  - LAT=1: DRIVE lasts exactly 1 cycle.
  - Reset mid-DRIVE or mid-RESP: the pending response is discarded, with no rsp_valid pulse after rst_n rises; op_count is cleared.

Test Plan:
- WIDTH=4, LAT=1. Send cmd opcode 1010, A=9, B=8; stub ALU computes {Y[0],X}=17 → alu_* buses = 1010/9/8 one cycle after accept. rsp_valid after edge k+1 with rsp_result=0x11 and rsp_err=0; op_count=1 after handshake.
- Send opcode 1011, A=3, B=5 → rsp_result=0x0E, rsp_err=1. Then send opcode 0110, A=7, B=2 with the stub driving alu_x=4'hF, alu_y=4'hF → rsp_result=0x01.
- LAT=3, opcode 1100, A=15, B=15 → rsp_valid asserts exactly 3 edges after accept with rsp_result=0xE1. cmd_ready=0 for all 4 busy cycles.
- Hold rsp_ready=0 for 5 cycles in RESP while cmd_valid=1 with a new command → rsp_* outputs stay stable and cmd_ready=0. The new command is accepted on the first IDLE cycle after the handshake.
- Opcode 1110, A=1, B=9 → rsp_err=1. Then assert rst_n=0 mid-DRIVE of a following command → all outputs 0 immediately and no rsp_valid after release.
- Issue 260 back-to-back commands with rsp_ready=1 → op_count saturates at 255.
